vga_rx_capture: RTL and testbench

//  Receive side of the VGA video interface: samples hs/vs/24-bit RGB from an external VGA-timed source.

---
 rtl/vga_rx_pkg.sv | 30 +++
 rtl/vga_sync_edge.sv | 30 +++
 rtl/vga_rx_capture.sv | 199 +++++++++++++++++++
 tb/tb_vga_rx_capture.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared types and constants for the VGA receive/capture block.
// Contents: lock FSM state enum, 640x480 timing defaults, counter widths and a
// saturating increment used by the line/frame measurement counters.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    StSearch,
    StTrack,
    StLocked
  } rx_state_e;

  // Counter widths: 12-bit timing measurement, 10-bit pixel coordinates.
  localparam int unsigned MeasW  = 12;
  localparam int unsigned CoordW = 10;

  localparam logic [MeasW-1:0] MeasMax = '1;

  // Standard 640x480 @ 60 Hz timing (25 MHz pixel clock).
  localparam int unsigned HTotal640  = 800;
  localparam int unsigned HStart640  = 144;
  localparam int unsigned HActive640 = 640;
  localparam int unsigned VTotal480  = 525;
  localparam int unsigned VStart480  = 35;
  localparam int unsigned VActive480 = 480;

  function automatic logic [MeasW-1:0] sat_inc(input logic [MeasW-1:0] v);
    return (v == MeasMax) ? v : v + MeasW'(1);
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync input stage: normalises the sync to active-high, registers it once and
// flags the leading (activating) edge of the registered signal.
// Ports:
//   clk, rst   pixel clock, asynchronous active-high reset
//   sync_in    raw sync from the source (active level set by SYNC_POL)
//   lead_edge  one-cycle pulse on the cycle the registered sync becomes active
module vga_sync_edge #(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic lead_edge
);

  logic sync_q, sync_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= (sync_in == SYNC_POL);
      sync_prev_q <= sync_q;
    end
  end

  assign lead_edge = sync_q & ~sync_prev_q;

endmodule

// File: rtl/vga_rx_capture.sv
// Receive side of the VGA interface. Samples hs/vs/RGB, measures line length
// and lines per frame, locks once timing repeats, then emits active-area pixels
// with x/y coordinates (rgb_in to pix_data latency is 2 clocks).
// Ports:
//   clk, rst             pixel clock, asynchronous active-high reset
//   hs_in, vs_in, rgb_in source sync and {R,G,B} pixel
//   pix_valid/pix_data   captured active pixel, x_pix/y_pix its coordinates
//   frame_start          pulse with pixel (0,0)
//   line_total           measured clocks per line
//   frame_lines          measured lines per frame
//   locked               timing stable, qualifies pix_valid
module vga_rx_capture
  import vga_rx_pkg::*;
#(
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned H_START     = HStart640,
  parameter int unsigned H_ACTIVE    = HActive640,
  parameter int unsigned V_START     = VStart480,
  parameter int unsigned V_ACTIVE    = VActive480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [23:0]       rgb_in,
  output logic              pix_valid,
  output logic [23:0]       pix_data,
  output logic [CoordW-1:0] x_pix,
  output logic [CoordW-1:0] y_pix,
  output logic              frame_start,
  output logic [MeasW-1:0]  line_total,
  output logic [MeasW-1:0]  frame_lines,
  output logic              locked
);

  logic hs_edge, vs_edge;

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
    .clk      (clk),
    .rst      (rst),
    .sync_in  (hs_in),
    .lead_edge(hs_edge)
  );

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
    .clk      (clk),
    .rst      (rst),
    .sync_in  (vs_in),
    .lead_edge(vs_edge)
  );

  logic [23:0]       rgb_q;
  logic [MeasW-1:0]  h_cnt_q, v_cnt_q, line_total_q, frame_lines_q;
  logic              vs_pend_q, line_err_q;
  rx_state_e         state_q;
  logic [7:0]        good_q;
  logic [2*MeasW-1:0] ref_q;
  logic              ref_vld_q, locked_q;
  logic              pix_valid_q, frame_start_q;
  logic [23:0]       pix_data_q;
  logic [CoordW-1:0] x_q, y_q;

  // h_cur/v_cur are the position of the pixel currently held in rgb_q.
  logic [MeasW-1:0]  h_cur, v_cur, line_meas, line_total_d, frame_lines_d;
  logic              boundary, meas_ok, line_mis, err_now, ref_match, hs_lost, active;
  logic [7:0]        good_inc;
  logic [CoordW-1:0] x_next, y_next;

  always_comb begin
    h_cur    = hs_edge ? '0 : sat_inc(h_cnt_q);
    // vs edge waits for the next hs edge so that the frame boundary is line 0.
    boundary = hs_edge & (vs_pend_q | vs_edge);
    if (boundary) begin
      v_cur = '0;
    end else if (hs_edge) begin
      v_cur = sat_inc(v_cnt_q);
    end else begin
      v_cur = v_cnt_q;
    end
    // A saturated count means the line was not really measured.
    meas_ok       = hs_edge && (h_cnt_q != MeasMax);
    line_meas     = h_cnt_q + MeasW'(1);
    line_mis      = meas_ok && (line_meas != line_total_q);
    line_total_d  = meas_ok ? line_meas : line_total_q;
    frame_lines_d = boundary ? sat_inc(v_cnt_q) : frame_lines_q;
    err_now       = line_err_q | line_mis;
    ref_match     = ({frame_lines_d, line_total_d} == ref_q);
    hs_lost       = (h_cur == MeasMax);
    good_inc      = good_q + 8'd1;
    active        = locked_q &&
                    (h_cur >= MeasW'(H_START)) && (h_cur < MeasW'(H_START + H_ACTIVE)) &&
                    (v_cur >= MeasW'(V_START)) && (v_cur < MeasW'(V_START + V_ACTIVE));
    x_next        = CoordW'(h_cur - MeasW'(H_START));
    y_next        = CoordW'(v_cur - MeasW'(V_START));
  end

  // Timing counters and measurements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_total_q  <= '0;
      frame_lines_q <= '0;
      vs_pend_q     <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      rgb_q         <= rgb_in;
      h_cnt_q       <= h_cur;
      v_cnt_q       <= v_cur;
      line_total_q  <= line_total_d;
      frame_lines_q <= frame_lines_d;
      vs_pend_q     <= boundary ? 1'b0 : (vs_pend_q | vs_edge);
      line_err_q    <= boundary ? 1'b0 : err_now;
    end
  end

  // Lock FSM, evaluated at frame boundaries; loss of hs overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StSearch;
      good_q    <= '0;
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
      locked_q  <= 1'b0;
    end else if (hs_lost) begin
      state_q   <= StSearch;
      ref_vld_q <= 1'b0;
      locked_q  <= 1'b0;
    end else if (boundary) begin
      unique case (state_q)
        StSearch: begin
          // The frame just ended was partial, so nothing is stored.
          state_q   <= StTrack;
          ref_vld_q <= 1'b0;
          good_q    <= '0;
        end
        StTrack: begin
          ref_q <= {frame_lines_d, line_total_d};
          if (!ref_vld_q) begin
            ref_vld_q <= 1'b1;
            good_q    <= '0;
          end else if (ref_match && !err_now) begin
            good_q <= good_inc;
            if (good_inc == 8'(LOCK_FRAMES)) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end
          end else begin
            good_q <= '0;
          end
        end
        StLocked: begin
          ref_q <= {frame_lines_d, line_total_d};
          if (!ref_match || err_now) begin
            state_q   <= StSearch;
            ref_vld_q <= 1'b0;
            locked_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= StSearch;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Pixel output register; data and coordinates hold outside the active area.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      pix_data_q    <= '0;
      x_q           <= '0;
      y_q           <= '0;
    end else if (active) begin
      pix_valid_q   <= 1'b1;
      frame_start_q <= (x_next == '0) && (y_next == '0);
      pix_data_q    <= rgb_q;
      x_q           <= x_next;
      y_q           <= y_next;
    end else begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign x_pix       = x_q;
  assign y_pix       = y_q;
  assign frame_start = frame_start_q;
  assign line_total  = line_total_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_vga_rx_capture.sv
// Scoreboard bench for vga_rx_capture using a reduced timing (16 clk lines,
// 10 line frames). Two instances: active-low syncs and SYNC_POL=1 with the
// syncs inverted; both must produce the same pixel stream.
module tb_vga_rx_capture;

  localparam int HT   = 16;  // clocks per line
  localparam int HS_W = 3;   // hs active width
  localparam int HS   = 5;   // H_START
  localparam int HA   = 6;   // H_ACTIVE
  localparam int VT   = 10;  // lines per frame
  localparam int VS_W = 2;   // vs active lines
  localparam int VS   = 3;   // V_START
  localparam int VA   = 4;   // V_ACTIVE

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] d;
    logic        fs;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_act, vs_act;
  logic [23:0] rgb;
  logic        hs_n, vs_n;

  logic        pv0, fs0, lk0, pv1, fs1, lk1;
  logic [23:0] pd0, pd1;
  logic [9:0]  x0, y0, x1, y1;
  logic [11:0] lt0, fl0, lt1, fl1;

  int   n_cmp = 0;
  int   n_err = 0;
  pix_t q0[$];
  pix_t q1[$];
  pix_t e0, e1;

  assign hs_n = ~hs_act;
  assign vs_n = ~vs_act;

  always #5 clk = ~clk;

  vga_rx_capture #(
    .SYNC_POL(1'b0), .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut0 (
    .clk(clk), .rst(rst), .hs_in(hs_n), .vs_in(vs_n), .rgb_in(rgb),
    .pix_valid(pv0), .pix_data(pd0), .x_pix(x0), .y_pix(y0), .frame_start(fs0),
    .line_total(lt0), .frame_lines(fl0), .locked(lk0)
  );

  vga_rx_capture #(
    .SYNC_POL(1'b1), .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut1 (
    .clk(clk), .rst(rst), .hs_in(hs_act), .vs_in(vs_act), .rgb_in(rgb),
    .pix_valid(pv1), .pix_data(pd1), .x_pix(x1), .y_pix(y1), .frame_start(fs1),
    .line_total(lt1), .frame_lines(fl1), .locked(lk1)
  );

  function automatic logic [23:0] rgb_of(input int f, input int l, input int c);
    return {8'(f), 8'(l), 8'(c)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_lock(input logic exp);
    chk("locked0", 32'(lk0), 32'(exp));
    chk("locked1", 32'(lk1), 32'(exp));
  endtask

  // Monitors: every presented pixel is popped and compared.
  always @(negedge clk) begin
    if (!rst && pv0) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL pix0_extra: got x=%0d y=%0d d=%0h, required no pixel", x0, y0, pd0);
      end else begin
        e0 = q0.pop_front();
        if ({x0, y0, pd0, fs0} !== e0) begin
          n_err++;
          $display("FAIL pix0: got x=%0d y=%0d d=%0h fs=%0b, required x=%0d y=%0d d=%0h fs=%0b",
                   x0, y0, pd0, fs0, e0.x, e0.y, e0.d, e0.fs);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && pv1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL pix1_extra: got x=%0d y=%0d d=%0h, required no pixel", x1, y1, pd1);
      end else begin
        e1 = q1.pop_front();
        if ({x1, y1, pd1, fs1} !== e1) begin
          n_err++;
          $display("FAIL pix1: got x=%0d y=%0d d=%0h fs=%0b, required x=%0d y=%0d d=%0h fs=%0b",
                   x1, y1, pd1, fs1, e1.x, e1.y, e1.d, e1.fs);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_pix_valid", 32'(pv0), 0);
    chk("rst_pix_data", 32'(pd0), 0);
    chk("rst_x", 32'(x0), 0);
    chk("rst_y", 32'(y0), 0);
    chk("rst_frame_start", 32'(fs0), 0);
    chk("rst_line_total", 32'(lt0), 0);
    chk("rst_frame_lines", 32'(fl0), 0);
    chk_lock(1'b0);
  endtask

  // Idle clocks with syncs inactive; optional lock checks at given indices.
  task automatic run_idle(input int n, input int chk_on, input int chk_off);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      hs_act = 1'b0;
      vs_act = 1'b0;
      rgb    = 24'(i);
      if (i == chk_on) chk_lock(1'b1);
      if (i == chk_off) begin
        chk_lock(1'b0);
        chk("lost_pix_valid", 32'(pv0), 0);
        chk("lost_line_total", 32'(lt0), HT);
      end
    end
  endtask

  // One frame. bad_line is shortened by one clock; rst_line gets a reset at col 9.
  task automatic send_frame(input int f, input bit push, input int bad_line, input int rst_line,
                            input int exp_lock, input bit hold_chk);
    pix_t p;
    int   len;
    for (int l = 0; l < VT; l++) begin
      len = (l == bad_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #1;
        hs_act = (c < HS_W);
        vs_act = (l < VS_W);
        rgb    = rgb_of(f, l, c);
        if (push && l >= VS && l < VS + VA && c >= HS && c < HS + HA &&
            !(l == rst_line && c > 7)) begin
          p.x  = 10'(c - HS);
          p.y  = 10'(l - VS);
          p.d  = rgb_of(f, l, c);
          p.fs = (c == HS) && (l == VS);
          q0.push_back(p);
          q1.push_back(p);
        end
        if (l == 0 && c == 4 && exp_lock >= 0) begin
          chk_lock(exp_lock[0]);
          if (exp_lock == 1) begin
            chk("line_total", 32'(lt0), HT);
            chk("frame_lines", 32'(fl0), VT);
            chk("line_total_p", 32'(lt1), HT);
          end
          if (hold_chk) begin
            chk("hold_x", 32'(x0), HA - 1);
            chk("hold_y", 32'(y0), VA - 1);
            chk("hold_data", 32'(pd0), 32'(rgb_of(f - 1, VS + VA - 1, HS + HA - 1)));
            chk("hold_valid", 32'(pv0), 0);
          end
        end
        if (l == rst_line && c == 9) begin
          @(negedge clk); #1;
          rst = 1'b1;
          #1;
          check_reset_outputs();
          repeat (3) @(posedge clk);
          #1;
          rst    = 1'b0;
          hs_act = 1'b0;
          vs_act = 1'b0;
          return;
        end
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    hs_act = 1'b0;
    vs_act = 1'b0;
    rgb    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    run_idle(5, -1, -1);

    // Initial lock: locked appears at the 4th boundary (start of frame 3).
    send_frame(0, 1'b0, -1, -1, 0, 1'b0);
    send_frame(1, 1'b0, -1, -1, 0, 1'b0);
    send_frame(2, 1'b0, -1, -1, 0, 1'b0);
    send_frame(3, 1'b1, -1, -1, 1, 1'b0);
    send_frame(4, 1'b1, -1, -1, 1, 1'b1);
    // One short line drops lock at the next boundary; relock four boundaries later.
    send_frame(5, 1'b1, 8, -1, 1, 1'b0);
    send_frame(6, 1'b0, -1, -1, 0, 1'b0);
    send_frame(7, 1'b0, -1, -1, 0, 1'b0);
    send_frame(8, 1'b0, -1, -1, 0, 1'b0);
    send_frame(9, 1'b0, -1, -1, 0, 1'b0);
    send_frame(10, 1'b1, -1, -1, 1, 1'b0);
    // hs lost: count saturates 4095 clocks after the last edge (line 9, frame 10).
    run_idle(4100, 4064, 4094);
    // Lock again, then reset mid active line.
    send_frame(11, 1'b0, -1, -1, 0, 1'b0);
    send_frame(12, 1'b0, -1, -1, 0, 1'b0);
    send_frame(13, 1'b0, -1, -1, 0, 1'b0);
    send_frame(14, 1'b1, -1, 4, 1, 1'b0);
    run_idle(5, -1, -1);
    send_frame(15, 1'b0, -1, -1, 0, 1'b0);
    send_frame(16, 1'b0, -1, -1, 0, 1'b0);
    send_frame(17, 1'b0, -1, -1, 0, 1'b0);
    send_frame(18, 1'b1, -1, -1, 1, 1'b0);
    run_idle(10, -1, -1);

    chk("q0_left", 32'(q0.size()), 0);
    chk("q1_left", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
